// File: rtl/srv_icb_copy.sv
// ICB block-copy initiator: moves len words from src_addr to dst_addr using
// strictly alternating, single-outstanding read/write ICB transactions.
module srv_icb_copy #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [LW-1:0]   len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            icb_cmd_valid,
    input  logic            icb_cmd_ready,
    output logic [AW-1:0]   icb_cmd_addr,
    output logic            icb_cmd_read,
    output logic [DW-1:0]   icb_cmd_wdata,
    output logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_resp_ready,
    input  logic            icb_resp_valid,
    input  logic [DW-1:0]   icb_resp_rdata,
    input  logic            icb_resp_err
);

    localparam int BW = DW / 8;
    localparam logic [AW-1:0] STEP = AW'(BW);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_RESP = 3'd2,
        WR_CMD  = 3'd3,
        WR_RESP = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_src, w_src_next;
    logic [AW-1:0]   r_dst, w_dst_next;
    logic [LW-1:0]   r_cnt, w_cnt_next;
    logic [LW-1:0]   w_cnt_dec;
    logic [DW-1:0]   r_data, w_data_next;
    logic            r_err, w_err_next;
    logic            r_busy, w_busy_next;
    logic            r_done, w_done_next;
    logic            r_cmd_valid, w_cmd_valid_next;
    logic            r_cmd_read, w_cmd_read_next;
    logic [AW-1:0]   r_cmd_addr, w_cmd_addr_next;
    logic [DW-1:0]   r_cmd_wdata, w_cmd_wdata_next;
    logic [BW-1:0]   r_cmd_wmask, w_cmd_wmask_next;
    logic            r_resp_ready, w_resp_ready_next;

    assign w_cnt_dec = r_cnt - LW'(1);

    always_comb begin
        w_state_next = r_state;
        w_src_next   = r_src;
        w_dst_next   = r_dst;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_err_next   = r_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_src_next   = src_addr;
                    w_dst_next   = dst_addr;
                    w_cnt_next   = len;
                    w_err_next   = 1'b0;
                    w_state_next = (len == '0) ? FIN : RD_CMD;
                end
            end
            RD_CMD: begin
                if (icb_cmd_ready) w_state_next = RD_RESP;
            end
            RD_RESP: begin
                if (icb_resp_valid) begin
                    w_data_next = icb_resp_rdata;
                    if (icb_resp_err) begin
                        w_err_next   = 1'b1;
                        w_state_next = FIN;
                    end else begin
                        w_state_next = WR_CMD;
                    end
                end
            end
            WR_CMD: begin
                if (icb_cmd_ready) w_state_next = WR_RESP;
            end
            WR_RESP: begin
                if (icb_resp_valid) begin
                    if (icb_resp_err) begin
                        w_err_next   = 1'b1;
                        w_state_next = FIN;
                    end else begin
                        w_src_next   = r_src + STEP;
                        w_dst_next   = r_dst + STEP;
                        w_cnt_next   = w_cnt_dec;
                        w_state_next = (w_cnt_dec == '0) ? FIN : RD_CMD;
                    end
                end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one leaves a flop.
    always_comb begin
        w_cmd_valid_next  = (w_state_next == RD_CMD) || (w_state_next == WR_CMD);
        w_resp_ready_next = (w_state_next == RD_RESP) || (w_state_next == WR_RESP);
        w_busy_next       = w_cmd_valid_next || w_resp_ready_next;
        w_done_next       = (w_state_next == FIN);
        w_cmd_read_next   = r_cmd_read;
        w_cmd_addr_next   = r_cmd_addr;
        w_cmd_wdata_next  = r_cmd_wdata;
        w_cmd_wmask_next  = r_cmd_wmask;
        if (w_state_next == RD_CMD) begin
            w_cmd_read_next  = 1'b1;
            w_cmd_addr_next  = w_src_next;
            w_cmd_wdata_next = '0;
            w_cmd_wmask_next = '0;
        end else if (w_state_next == WR_CMD) begin
            w_cmd_read_next  = 1'b0;
            w_cmd_addr_next  = w_dst_next;
            w_cmd_wdata_next = w_data_next;
            w_cmd_wmask_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_read   <= 1'b1;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_wmask  <= '0;
            r_resp_ready <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_src        <= w_src_next;
            r_dst        <= w_dst_next;
            r_cnt        <= w_cnt_next;
            r_data       <= w_data_next;
            r_err        <= w_err_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_cmd_valid  <= w_cmd_valid_next;
            r_cmd_read   <= w_cmd_read_next;
            r_cmd_addr   <= w_cmd_addr_next;
            r_cmd_wdata  <= w_cmd_wdata_next;
            r_cmd_wmask  <= w_cmd_wmask_next;
            r_resp_ready <= w_resp_ready_next;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign icb_cmd_valid  = r_cmd_valid;
    assign icb_cmd_read   = r_cmd_read;
    assign icb_cmd_addr   = r_cmd_addr;
    assign icb_cmd_wdata  = r_cmd_wdata;
    assign icb_cmd_wmask  = r_cmd_wmask;
    assign icb_resp_ready = r_resp_ready;

endmodule

// File: tb/tb_srv_icb_copy.sv
// Bench for srv_icb_copy: randomized ICB responder with stalls/errors, checked
// against a word-by-word copy model of the expected transaction sequence.
module tb_srv_icb_copy;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   src_addr = '0;
    logic [AW-1:0]   dst_addr = '0;
    logic [LW-1:0]   len = '0;
    logic            busy, done, err;
    logic            icb_cmd_valid;
    logic            icb_cmd_ready = 1'b0;
    logic [AW-1:0]   icb_cmd_addr;
    logic            icb_cmd_read;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_resp_ready;
    logic            icb_resp_valid = 1'b0;
    logic [DW-1:0]   icb_resp_rdata = '0;
    logic            icb_resp_err = 1'b0;

    always #5 clk = ~clk;

    srv_icb_copy #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .icb_cmd_valid  (icb_cmd_valid),
        .icb_cmd_ready  (icb_cmd_ready),
        .icb_cmd_addr   (icb_cmd_addr),
        .icb_cmd_read   (icb_cmd_read),
        .icb_cmd_wdata  (icb_cmd_wdata),
        .icb_cmd_wmask  (icb_cmd_wmask),
        .icb_resp_ready (icb_resp_ready),
        .icb_resp_valid (icb_resp_valid),
        .icb_resp_rdata (icb_resp_rdata),
        .icb_resp_err   (icb_resp_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    txn_t        log_q[$];
    txn_t        exp_q[$];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Responder configuration and state
    int          cfg_stall = 0;
    int          cfg_delay = 0;
    int          cfg_err_idx = -1;
    bit          cfg_spur = 0;
    bit          cfg_hold_wr = 0;
    int          rd_count = 0;
    bit          pend = 0;
    int          pend_dly = 0;
    logic [31:0] pend_data = '0;
    bit          pend_err = 0;
    int          stall_left = 0;
    bit          cmd_seen = 0;
    logic [31:0] snap_addr = '0;
    logic [31:0] snap_wdata = '0;
    logic [3:0]  snap_wmask = '0;
    logic        snap_read = 1'b0;

    always @(negedge clk) begin
        logic [31:0] d;
        icb_resp_valid = 1'b0;
        icb_resp_err   = 1'b0;
        icb_resp_rdata = $urandom;
        if (pend) begin
            if (pend_dly > 0) begin
                pend_dly--;
            end else begin
                icb_resp_valid = 1'b1;
                icb_resp_rdata = pend_data;
                icb_resp_err   = pend_err;
                if (icb_resp_ready) pend = 0;
            end
        end else if (cfg_spur && $urandom_range(0, 1) == 1) begin
            icb_resp_valid = 1'b1;
            icb_resp_err   = 1'b1;
        end

        icb_cmd_ready = 1'($urandom_range(0, 1));
        if (icb_cmd_valid === 1'b1) begin
            if (!cmd_seen) begin
                cmd_seen   = 1;
                snap_addr  = icb_cmd_addr;
                snap_read  = icb_cmd_read;
                snap_wdata = icb_cmd_wdata;
                snap_wmask = icb_cmd_wmask;
                stall_left = cfg_stall;
            end else begin
                chk("stall_addr", icb_cmd_addr, snap_addr);
                chk("stall_read", icb_cmd_read, snap_read);
                chk("stall_wdata", icb_cmd_wdata, snap_wdata);
                chk("stall_wmask", icb_cmd_wmask, snap_wmask);
            end
            if (stall_left > 0 || (cfg_hold_wr && !icb_cmd_read)) begin
                if (stall_left > 0) stall_left--;
                icb_cmd_ready = 1'b0;
            end else begin
                icb_cmd_ready = 1'b1;
                cmd_seen = 0;
                if (icb_cmd_read) begin
                    chk("rd_wdata", icb_cmd_wdata, 0);
                    chk("rd_wmask", icb_cmd_wmask, 0);
                    d = mem.exists(icb_cmd_addr) ? mem[icb_cmd_addr] : def_word(icb_cmd_addr);
                    log_q.push_back('{1'b1, icb_cmd_addr, d});
                    pend_data = d;
                    pend_err  = (rd_count == cfg_err_idx);
                    rd_count++;
                end else begin
                    chk("wr_wmask", icb_cmd_wmask, 4'hF);
                    mem[icb_cmd_addr] = icb_cmd_wdata;
                    log_q.push_back('{1'b0, icb_cmd_addr, icb_cmd_wdata});
                    pend_data = $urandom;
                    pend_err  = 0;
                end
                pend     = 1;
                pend_dly = cfg_delay;
            end
        end else begin
            cmd_seen = 0;
        end
    end

    // Reference: sequential word copy on a private memory image.
    task automatic model(input logic [31:0] s, input logic [31:0] dd, input int n,
                         input int eidx, output bit exp_err, output int exp_lat);
        logic [31:0] a, w;
        exp_q.delete();
        ref_mem = mem;
        exp_err = 0;
        exp_lat = 1 + 4 * n;
        for (int i = 0; i < n; i++) begin
            a = s + 32'(4 * i);
            w = ref_mem.exists(a) ? ref_mem[a] : def_word(a);
            exp_q.push_back('{1'b1, a, w});
            if (i == eidx) begin
                exp_err = 1;
                exp_lat = 3 + 4 * i;
                break;
            end
            a = dd + 32'(4 * i);
            ref_mem[a] = w;
            exp_q.push_back('{1'b0, a, w});
        end
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] dd, input int n,
                            input int stall, input int dly, input int eidx,
                            input bit spam, input bit poke_fin);
        bit exp_err;
        int exp_lat;
        int st;
        bit got_done;
        int extra;
        cfg_stall   = stall;
        cfg_delay   = dly;
        cfg_err_idx = eidx;
        rd_count    = 0;
        log_q.delete();
        model(s, dd, n, eidx, exp_err, exp_lat);

        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = dd; len = LW'(n);
        st = cyc;
        @(negedge clk);
        start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = LW'($urandom_range(1, 9));
        chk("busy_after_start", busy, (n != 0));

        got_done = 0;
        for (int t = 0; t < 3000 && !got_done; t++) begin
            if (done === 1'b1) begin
                got_done = 1;
                if (stall == 0 && dly == 0) chk("done_latency", cyc - st, exp_lat);
                chk("busy_at_done", busy, 0);
                if (poke_fin) begin
                    start = 1'b1; len = LW'($urandom_range(1, 5));
                end
            end else begin
                start = (spam && $urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_fin", busy, 0);
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        chk("extra_done_or_busy", extra, 0);
        chk("err", err, exp_err);
        chk("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("txn%0d_rd", i), log_q[i].rd, exp_q[i].rd);
            chk($sformatf("txn%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("txn%0d_data", i), log_q[i].data, exp_q[i].data);
        end
        $display("copy src=%08h dst=%08h len=%0d stall=%0d dly=%0d eidx=%0d txns=%0d err=%0b",
                 s, dd, n, stall, dly, eidx, log_q.size(), err);
    endtask

    task automatic reset_mid_copy();
        bit hit;
        int extra;
        cfg_stall = 0; cfg_delay = 0; cfg_err_idx = -1; cfg_hold_wr = 1;
        rd_count = 0;
        log_q.delete();
        @(negedge clk);
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h800; len = LW'(3);
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int t = 0; t < 50 && !hit; t++) begin
            if (icb_cmd_valid === 1'b1 && icb_cmd_read === 1'b0) begin
                hit = 1;
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("reach_wr_cmd", hit, 1);
        @(negedge clk);
        reset = 1'b0;
        cfg_hold_wr = 0;
        chk("rst_mid_cmd_valid", icb_cmd_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_resp_ready", icb_resp_ready, 0);
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done === 1'b1 || icb_cmd_valid === 1'b1) extra++;
        end
        chk("rst_mid_quiet", extra, 0);
        chk("rst_mid_txns", log_q.size(), 1);
        $display("reset mid-copy: txns=%0d", log_q.size());
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; len = LW'(5); src_addr = 32'h40; dst_addr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_cmd_valid", icb_cmd_valid, 0);
        end
        chk("rst_resp_ready", icb_resp_ready, 0);
        chk("rst_cmd_read", icb_cmd_read, 1);
        chk("rst_cmd_addr", icb_cmd_addr, 0);
        chk("rst_cmd_wdata", icb_cmd_wdata, 0);
        chk("rst_cmd_wmask", icb_cmd_wmask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        start = 1'b0;
        reset = 1'b0;
        $display("reset held 3 cycles with start=1");

        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

        run_copy(32'h100, 32'h200, 4, 0, 0, -1, 0, 0);
        run_copy(32'h100, 32'h200, 4, 3, 2, -1, 1, 0);
        run_copy(32'h100, 32'h200, 4, 0, 0, 1, 0, 0);
        run_copy(32'h300, 32'h400, 1, 0, 0, -1, 0, 1);
        run_copy(32'h500, 32'h600, 0, 0, 0, -1, 0, 1);
        run_copy(32'hFFFF_FFFC, 32'h700, 2, 0, 0, -1, 0, 0);
        reset_mid_copy();
        run_copy(32'h100, 32'h900, 2, 0, 0, -1, 0, 0);

        cfg_spur = 1;
        for (int r = 0; r < 12; r++) begin
            int n, e;
            n = $urandom_range(1, 6);
            e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, n,
                     $urandom_range(0, 2), $urandom_range(0, 2), e,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
